// File: rtl/hex_display_ctrl.sv
// Multi-channel seven-segment display controller: registered capture, hex or BCD
// digit build, leading-zero blanking, overflow dashes and blink. Define HEXDISP_BCD_EN for decimal.
module hex_display_ctrl #(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_W     = 16,
    parameter  int NUM_DIGITS = 4,
    parameter  int BLINK_DIV  = 12500000,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clock,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [SEL_W-1:0]         ch_sel,
    input  logic                     update,
    input  logic                     blank_lz,
    input  logic                     blink_en,
    output logic                     busy,
    output logic                     valid,
    output logic                     overflow,
    output logic [SEL_W-1:0]         cur_ch,
    output logic [NUM_DIGITS*7-1:0]  seg
);

    localparam int DW4 = 4 * NUM_DIGITS;
    localparam int BW  = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  val_q, val_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               pend_q, pend_d;
    logic [SEL_W-1:0]   psel_q, psel_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [DW4-1:0]     dig_q, dig_d;
    logic [DW4-1:0]     work_q, work_d;
    logic               wovf_q, wovf_d;
    logic [BW-1:0]      bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
    logic               start;
    logic [SEL_W-1:0]   start_sel;
    logic [DATA_W-1:0]  cap_val;

`ifdef HEXDISP_BCD_EN
    localparam int CW = $clog2(DATA_W + 1);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW4-1:0]     adj;
`else
    localparam int MW = (DATA_W > DW4) ? DATA_W : DW4;
    logic [MW-1:0]      val_ext;
`endif

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
            4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
            4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
            4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        sel_d     = sel_q;
        pend_d    = pend_q;
        psel_d    = psel_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        cur_d     = cur_q;
        dig_d     = dig_q;
        work_d    = work_q;
        wovf_d    = wovf_q;
        start     = 1'b0;
        start_sel = ch_sel;
        cap_val   = '0;
`ifdef HEXDISP_BCD_EN
        cnt_d     = cnt_q;
        adj       = work_q;
`else
        val_ext   = MW'(val_q);
`endif
        case (state_q)
            IDLE: start = update;
            CONV: begin
                if (update) begin
                    pend_d = 1'b1;
                    psel_d = ch_sel;
                end
`ifdef HEXDISP_BCD_EN
                // double-dabble step: add 3 to digits >= 5, then shift the next value bit in
                for (int unsigned i = 0; i < NUM_DIGITS; i++)
                    if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                wovf_d = wovf_q | adj[DW4-1];
                work_d = {adj[DW4-2:0], val_q[DATA_W-1]};
                val_d  = val_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) state_d = DONE;
`else
                work_d  = val_ext[DW4-1:0];
                wovf_d  = |(val_ext >> DW4);
                state_d = DONE;
`endif
            end
            DONE: begin
                dig_d   = work_q;
                ovf_d   = wovf_q;
                valid_d = 1'b1;
                cur_d   = sel_q;
                // an update arriving in DONE merges with any queued one, newest select wins
                if (pend_q || update) begin
                    start     = 1'b1;
                    start_sel = update ? ch_sel : psel_q;
                    pend_d    = 1'b0;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < NUM_CH; k++)
            if (start_sel == SEL_W'(k)) cap_val = ch_data[k*DATA_W +: DATA_W];

        if (start) begin
            val_d   = cap_val;
            sel_d   = start_sel;
            busy_d  = 1'b1;
            work_d  = '0;
            wovf_d  = 1'b0;
            state_d = CONV;
`ifdef HEXDISP_BCD_EN
            cnt_d   = '0;
`endif
        end
    end

    always_comb begin
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            sel_q   <= '0;
            pend_q  <= 1'b0;
            psel_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cur_q   <= '0;
            dig_q   <= '0;
            work_q  <= '0;
            wovf_q  <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
`ifdef HEXDISP_BCD_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            psel_q  <= psel_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cur_q   <= cur_d;
            dig_q   <= dig_d;
            work_q  <= work_d;
            wovf_q  <= wovf_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`ifdef HEXDISP_BCD_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        logic        seen;
        int unsigned i;
        logic [3:0]  nib;
        seg  = '1;
        seen = 1'b0;
        i    = 0;
        nib  = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            i   = NUM_DIGITS - 1 - k;
            nib = dig_q[4*i +: 4];
            if (nib != 4'd0 || i == 0) seen = 1'b1;
            if (ovf_q)                 seg[7*i +: 7] = 7'h3F;
            else if (blank_lz && !seen) seg[7*i +: 7] = 7'h7F;
            else                       seg[7*i +: 7] = enc(nib);
        end
        if (!valid_q || (blink_en && phase_q)) seg = '1;
    end

    assign busy     = busy_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign cur_ch   = cur_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised self-checking bench for hex_display_ctrl against a digit-arithmetic model.
module tb_hex_display_ctrl;

    localparam int ND  = 4;
    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int BD  = 4;
`ifdef HEXDISP_BCD_EN
    localparam int LAT  = DW + 1;
    localparam int BASE = 10;
`else
    localparam int LAT  = 2;
    localparam int BASE = 16;
`endif
    localparam logic [ND*7-1:0] ALL_OFF = {ND{7'h7F}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] ch_data;
    logic [1:0]        ch_sel;
    logic              update, blank_lz, blink_en;
    logic              busy, valid, overflow;
    logic [1:0]        cur_ch;
    logic [ND*7-1:0]   seg;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned chd [NCH];
    int unsigned edges;
    bit          valid_seen;

    logic [6:0] ENC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_ctrl #(.NUM_CH(NCH), .DATA_W(DW), .NUM_DIGITS(ND), .BLINK_DIV(BD)) dut (
        .Clock(clk), .reset(rst_n), .ch_data(ch_data), .ch_sel(ch_sel), .update(update),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .valid(valid),
        .overflow(overflow), .cur_ch(cur_ch), .seg(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ovf(input int unsigned v);
        longint unsigned lim = 1;
        for (int i = 0; i < ND; i++) lim = lim * BASE;
        return longint'(v) >= lim;
    endfunction

    function automatic logic [ND*7-1:0] model_seg(input int unsigned v, input bit blank);
        int unsigned d [ND];
        int unsigned p = 1;
        int          msd = 0;
        logic [ND*7-1:0] s;
        for (int i = 0; i < ND; i++) begin
            d[i] = (v / p) % BASE;
            p    = p * BASE;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < ND; i++) begin
            if (model_ovf(v))            s[i*7 +: 7] = 7'h3F;
            else if (blank && i > msd)   s[i*7 +: 7] = 7'h7F;
            else                         s[i*7 +: 7] = ENC[d[i]];
        end
        return s;
    endfunction

    task automatic set_ch(input int k, input int unsigned v);
        chd[k] = v & 32'hFFFF;
        ch_data[k*DW +: DW] = v[DW-1:0];
    endtask

    task automatic run_txn(input int sel, input bit blank);
        int n = 0;
        blank_lz = blank;
        ch_sel   = sel[1:0];
        update   = 1'b1;
        @(negedge clk);
        update = 1'b0;
        if (!valid_seen) check_eq("pre_valid_seg", seg, ALL_OFF);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_eq("busy_cycles", n, LAT);
        check_eq("seg", seg, model_seg(chd[sel], blank));
        check_eq("overflow", overflow, model_ovf(chd[sel]));
        check_eq("valid", valid, 1'b1);
        check_eq("cur_ch", cur_ch, sel);
        valid_seen = 1'b1;
        blank_lz = ~blank;
        @(negedge clk);
        check_eq("seg_blank_toggle", seg, model_seg(chd[sel], ~blank));
    endtask

    // second request queued at negedge qn; its channel value is changed at the same time
    task automatic run_pend(input int qn, input int unsigned a, input int unsigned b0,
                            input int unsigned b1);
        int gaps = 0;
        blank_lz = 1'b0;
        set_ch(1, a);
        set_ch(3, b0);
        ch_sel = 2'd1;
        update = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 2*LAT; n++) begin
            if (busy !== 1'b1) gaps++;
            if (n == LAT) begin
                check_eq("pend_first_seg", seg, model_seg(a, 1'b0));
                check_eq("pend_first_ch", cur_ch, 2'd1);
            end
            if (n == 0) update = 1'b0;
            if (n == qn) begin
                ch_sel = 2'd3;
                update = 1'b1;
                set_ch(3, b1);
            end else if (n == qn + 1) begin
                update = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("pend_busy_gaps", gaps, 0);
        check_eq("pend_busy_end", busy, 1'b0);
        check_eq("pend_second_seg", seg, model_seg(b1, 1'b0));
        check_eq("pend_second_ch", cur_ch, 2'd3);
    endtask

    initial begin
        rst_n      = 1'b0;
        ch_data    = '0;
        ch_sel     = '0;
        update     = 1'b0;
        blank_lz   = 1'b0;
        blink_en   = 1'b0;
        valid_seen = 1'b0;
        #3;
        check_eq("rst_seg", seg, ALL_OFF);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_cur", cur_ch, 2'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_ch(0, $urandom_range(0, 65535));
        set_ch(1, $urandom_range(0, 65535));
        set_ch(2, 32'h0A3F);
        set_ch(3, $urandom_range(0, 65535));
        run_txn(2, 1'b0);
        run_txn(2, 1'b1);
        set_ch(1, 1234);   run_txn(1, 1'b0);
        set_ch(1, 12345);  run_txn(1, 1'b1);
        set_ch(0, 0);      run_txn(0, 1'b1);
        set_ch(3, 9999);   run_txn(3, 1'b1);
        set_ch(3, 10000);  run_txn(3, 1'b0);
        set_ch(3, 65535);  run_txn(3, 1'b0);

        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < NCH; k++)
                set_ch(k, $urandom_range(0, 1) ? $urandom_range(0, 12000) : $urandom_range(0, 65535));
            run_txn($urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        run_pend(0, 1111, 2222, $urandom_range(0, 9999));
        run_pend(LAT - 1, 4321, 5555, $urandom_range(0, 9999));

        set_ch(2, 16'h0A3F);
        ch_sel = 2'd2;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_seg", seg, ALL_OFF);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_valid", valid, 1'b0);
        check_eq("midrst_cur", cur_ch, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check_eq("midrst_no_update", seg, ALL_OFF);
        check_eq("midrst_still_invalid", valid, 1'b0);

        run_txn(2, 1'b0);
        blank_lz = 1'b0;
        blink_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            check_eq("blink_on", seg,
                     (((edges / BD) % 2) == 1) ? ALL_OFF : model_seg(chd[2], 1'b0));
        end
        blink_en = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_eq("blink_off", seg, model_seg(chd[2], 1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
